// File: rtl/comp_seq_ctrl.sv
// Magnitude comparator that steps one 4-bit slice over the operands, MS nibble first,
// with an early exit on the first unequal nibble and an IEEE-754 sign-magnitude mode.
module comp_seq_ctrl #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_mode,
   input  logic [DATA_WIDTH-1:0] i_data_a,
   input  logic [DATA_WIDTH-1:0] i_data_b,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_less,
   output logic                  o_equal,
   output logic                  o_greater,
   output logic                  o_busy
);

   localparam int NIB = DATA_WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [DATA_WIDTH-1:0] mag_a_q, mag_a_d;
   logic [DATA_WIDTH-1:0] mag_b_q, mag_b_d;
   logic                  sign_a_q, sign_a_d;
   logic                  sign_b_q, sign_b_d;
   logic                  fp_q, fp_d;
   logic                  less_q, less_d;
   logic                  equal_q, equal_d;
   logic                  greater_q, greater_d;
   logic                  valid_q, valid_d;

   logic [DATA_WIDTH-1:0] in_mag_a, in_mag_b;
   logic                  zero_a, zero_b;
   logic [3:0]            nib_a [NIB];
   logic [3:0]            nib_b [NIB];
   logic [3:0]            slice_a, slice_b;
   logic                  less_k, equal_k, swap;

   // FP mode strips the sign so the stepped compare only ever sees magnitudes.
   always_comb begin
      in_mag_a = i_data_a;
      in_mag_b = i_data_b;
      if (i_mode) begin
         in_mag_a[DATA_WIDTH-1] = 1'b0;
         in_mag_b[DATA_WIDTH-1] = 1'b0;
      end
   end

   assign zero_a = ~|in_mag_a;
   assign zero_b = ~|in_mag_b;

   for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
      assign nib_a[gi] = mag_a_q[gi*4 +: 4];
      assign nib_b[gi] = mag_b_q[gi*4 +: 4];
   end

   // The one shared slice: a nibble mux feeding a single 4-bit compare.
   assign slice_a = nib_a[idx_q];
   assign slice_b = nib_b[idx_q];
   assign less_k  = slice_a < slice_b;
   assign equal_k = slice_a == slice_b;
   assign swap    = fp_q & sign_a_q & sign_b_q;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      mag_a_d   = mag_a_q;
      mag_b_d   = mag_b_q;
      sign_a_d  = sign_a_q;
      sign_b_d  = sign_b_q;
      fp_d      = fp_q;
      less_d    = less_q;
      equal_d   = equal_q;
      greater_d = greater_q;
      valid_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               mag_a_d  = in_mag_a;
               mag_b_d  = in_mag_b;
               sign_a_d = i_mode & i_data_a[DATA_WIDTH-1];
               sign_b_d = i_mode & i_data_b[DATA_WIDTH-1];
               fp_d     = i_mode;
               idx_d    = IW'(NIB - 1);
               if (i_mode && zero_a && zero_b) begin
                  less_d    = 1'b0;
                  equal_d   = 1'b1;
                  greater_d = 1'b0;
                  valid_d   = 1'b1;
                  state_d   = S_DONE;
               end else if (i_mode && (i_data_a[DATA_WIDTH-1] != i_data_b[DATA_WIDTH-1])) begin
                  less_d    = i_data_a[DATA_WIDTH-1];
                  equal_d   = 1'b0;
                  greater_d = ~i_data_a[DATA_WIDTH-1];
                  valid_d   = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (!equal_k) begin
               less_d    = less_k ^ swap;
               equal_d   = 1'b0;
               greater_d = ~less_k ^ swap;
               valid_d   = 1'b1;
               state_d   = S_DONE;
            end else if (idx_q == '0) begin
               less_d    = 1'b0;
               equal_d   = 1'b1;
               greater_d = 1'b0;
               valid_d   = 1'b1;
               state_d   = S_DONE;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         S_DONE: begin
            valid_d = ~i_ready;
            if (i_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         mag_a_q   <= '0;
         mag_b_q   <= '0;
         sign_a_q  <= 1'b0;
         sign_b_q  <= 1'b0;
         fp_q      <= 1'b0;
         less_q    <= 1'b0;
         equal_q   <= 1'b0;
         greater_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         mag_a_q   <= mag_a_d;
         mag_b_q   <= mag_b_d;
         sign_a_q  <= sign_a_d;
         sign_b_q  <= sign_b_d;
         fp_q      <= fp_d;
         less_q    <= less_d;
         equal_q   <= equal_d;
         greater_q <= greater_d;
         valid_q   <= valid_d;
      end
   end

   assign o_ready   = (state_q == S_IDLE);
   assign o_busy    = (state_q != S_IDLE);
   assign o_valid   = valid_q;
   assign o_less    = less_q;
   assign o_equal   = equal_q;
   assign o_greater = greater_q;

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Randomised plus directed bench for comp_seq_ctrl against a value-level reference model.
module tb_comp_seq_ctrl;

   localparam int DW  = 32;
   localparam int NIB = DW / 4;

   logic          clk = 1'b0;
   logic          rst, in_valid, out_ready, mode, out_valid, in_ready;
   logic          less, equal, greater, busy;
   logic [DW-1:0] data_a, data_b;

   int n_checks = 0;
   int n_fail   = 0;

   comp_seq_ctrl #(.DATA_WIDTH(DW)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(out_ready),
      .i_mode(mode), .i_data_a(data_a), .i_data_b(data_b),
      .o_valid(out_valid), .i_ready(in_ready),
      .o_less(less), .o_equal(equal), .o_greater(greater), .o_busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Number of nibbles examined: leading equal nibbles, plus the deciding one, capped at NIB.
   function automatic int nib_count(input logic [DW-1:0] x, input logic [DW-1:0] y);
      int cnt = 0;
      for (int k = NIB - 1; k >= 0; k--) begin
         cnt++;
         if (((x >> (4 * k)) & 4'hF) != ((y >> (4 * k)) & 4'hF)) return cnt;
      end
      return cnt;
   endfunction

   // res = {less, equal, greater}; lat = cycles from accept to o_valid.
   task automatic model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic m,
                        output logic [2:0] res, output int lat);
      logic [DW-1:0] ma, mb;
      logic sa, sb;
      if (!m) begin
         res = (a < b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001;
         lat = nib_count(a, b) + 1;
      end else begin
         sa = a[DW-1];
         sb = b[DW-1];
         ma = a & {1'b0, {(DW-1){1'b1}}};
         mb = b & {1'b0, {(DW-1){1'b1}}};
         if (ma == 0 && mb == 0) begin
            res = 3'b010; lat = 1;
         end else if (sa != sb) begin
            res = sa ? 3'b100 : 3'b001; lat = 1;
         end else begin
            if (ma == mb) res = 3'b010;
            else if ((ma < mb) != sa) res = 3'b100;
            else res = 3'b001;
            lat = nib_count(ma, mb) + 1;
         end
      end
   endtask

   // Issues one request, checks latency/result/busy, holds the result for hold cycles.
   task automatic run_req(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic m, input int hold);
      logic [2:0] exp_res;
      int exp_lat, lat;
      model(a, b, m, exp_res, exp_lat);
      check({tag, "_ready"}, out_ready, 1'b1);
      in_valid = 1'b1; data_a = a; data_b = b; mode = m;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         check({tag, "_busy_run"}, busy, 1'b1);
         check({tag, "_ready_run"}, out_ready, 1'b0);
         tick();
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_result"}, {less, equal, greater}, exp_res);
      check({tag, "_busy_done"}, busy, 1'b1);
      for (int h = 0; h < hold; h++) begin
         in_valid = $urandom_range(0, 1);
         data_a   = $urandom;
         data_b   = $urandom;
         mode     = $urandom_range(0, 1);
         tick();
         check({tag, "_hold"}, {out_valid, out_ready, less, equal, greater}, {2'b10, exp_res});
      end
      in_valid = 1'b0;
      in_ready = 1'b1;
      tick();
      in_ready = 1'b0;
      check({tag, "_release"}, {out_valid, out_ready, busy}, 3'b010);
      $display("req %s mode=%0d a=%08h b=%08h lat=%0d res=%03b", tag, m, a, b, lat, exp_res);
   endtask

   initial begin
      logic [DW-1:0] ra, rb, mask;
      logic [63:0] wide;
      logic rm;
      rst = 1'b1; in_valid = 1'b0; in_ready = 1'b0; mode = 1'b0;
      data_a = '0; data_b = '0;
      tick(); tick();
      rst = 1'b0;
      check("reset_out", {out_valid, less, equal, greater, busy, out_ready}, 6'b000001);

      run_req("u_lt_full", 32'h12345678, 32'h12345679, 1'b0, 0);
      run_req("u_gt_msn",  32'h80000000, 32'h00000000, 1'b0, 0);
      run_req("u_eq",      32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0);
      run_req("fp_zeros",  32'h80000000, 32'h00000000, 1'b1, 0);
      run_req("fp_sign",   32'h3F800000, 32'hBF800000, 1'b1, 0);
      run_req("fp_negneg", 32'hC0000000, 32'hBF800000, 1'b1, 0);
      run_req("backpress", 32'h00001000, 32'h00000FFF, 1'b0, 3);
      run_req("after_bp",  32'h3F800000, 32'h3F800001, 1'b1, 0);

      // Reset in the middle of a long compare.
      check("mid_ready", out_ready, 1'b1);
      in_valid = 1'b1; data_a = 32'h12345678; data_b = 32'h12345679; mode = 1'b0;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_reset_out", {out_valid, less, equal, greater, busy, out_ready}, 6'b000001);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("mid_no_valid", {out_valid, out_ready}, 2'b01);
      end
      run_req("post_reset", 32'h12345678, 32'h12345679, 1'b0, 0);

      for (int i = 0; i < 60; i++) begin
         ra   = $urandom;
         wide = (64'h1 << (4 * $urandom_range(0, NIB))) - 64'h1;
         mask = wide[DW-1:0];
         rb   = ra ^ ($urandom & mask);
         rm   = $urandom_range(0, 1);
         if (rm && $urandom_range(0, 7) == 0) begin
            ra = {ra[DW-1], {(DW-1){1'b0}}};
            rb = {rb[DW-1], {(DW-1){1'b0}}};
         end
         if (rm && $urandom_range(0, 3) == 0) rb[DW-1] = ~rb[DW-1];
         run_req($sformatf("rnd%0d", i), ra, rb, rm, $urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
